dmem_byte_sequencer: RTL and testbench
======================================

Name: dmem_byte_sequencer

Overview:
- Load/store front-end between the MEM pipeline stage and the byte-wide dual-port data RAM (15-bit byte address, 8-bit data per port, registered read data, 1-cycle read latency).
- Converts one byte/half/word access into byte transactions, two bytes per cycle (port A = even lane, port B = odd lane).
- Returns sign- or zero-extended load data, or a store-done pulse.
- Holds the pipeline through the `req_ready` handshake.

Parameters:
- ADDR_W, 15, RAM byte-address width; `req_addr` is truncated to `[ADDR_W-1:0]`.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE; request accepted when `req_valid & req_ready`
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned  in  1  load zero-extend (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, little-endian
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  32  load result, valid with `rsp_valid`; 0 for stores
- rsp_err  out  1  misalignment flag (optional feature only; otherwise 0)
- ram_addr_a  out  ADDR_W  RAM port A address
- ram_wdata_a  out  8  RAM port A write data
- ram_we_a  out  1  RAM port A write enable
- ram_rdata_a  in  8  RAM port A registered read data
- ram_addr_b  out  ADDR_W  RAM port B address
- ram_wdata_b  out  8  RAM port B write data
- ram_we_b  out  1  RAM port B write enable
- ram_rdata_b  in  8  RAM port B registered read data

Behaviour:
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ram_we_a`/`ram_we_b`=0, RAM addresses/wdata=0.
- Acceptance: on accept, latch we, size, unsigned, `addr[ADDR_W-1:0]` (base A0) and wdata. All RAM port outputs are driven from registers.
- FSM states: IDLE, ISSUE0, ISSUE1, CAPT, DONE.
- IDLE -> ISSUE0 on accept.
- ISSUE0 drives the first pair:
  - `ram_addr_a`=A0, `ram_addr_b`=A0+1 (mod 2^ADDR_W).
  - Store: `we_a`=1 with byte0; `we_b`=1 with byte1 only for half/word.
- ISSUE0 exits:
  - Word -> ISSUE1.
  - Byte/half load -> CAPT.
  - Byte/half store -> DONE.
- ISSUE1 drives the second pair:
  - `addr_a`=A0+2, `addr_b`=A0+3 (mod 2^ADDR_W).
  - Store: both we=1 with byte2/byte3.
  - Load: capture `ram_rdata_a`/`ram_rdata_b` as bytes 0/1.
  - Exits: load -> CAPT, store -> DONE.
- CAPT: capture the pending pair (bytes 0/1 for byte/half, bytes 2/3 for word) -> DONE.
- DONE:
  - `rsp_valid`=1 for one cycle, `rsp_rdata` assembled little-endian.
  - Byte: bit 7 is sign-extended unless `req_unsigned`. Half: bit 15 likewise. Word: no extension.
  - `req_ready`=1 in DONE is not allowed; DONE -> IDLE.
- Both we deasserted in every state other than ISSUE0/ISSUE1 for stores.
- Latency from accept edge to `rsp_valid`:
  - byte/half store: 2 cycles
  - word store: 3 cycles
  - byte/half load: 3 cycles
  - word load: 4 cycles
- Throughput: next accept occurs the cycle after DONE.
- Address wrap: A0 near 2^ADDR_W-1 wraps through 0; no error.
- Port A/B addresses always differ, so no same-address dual write occurs.
- `req_valid` while not ready: ignored; the requester must hold the request.
- Reset mid-operation: immediate return to reset values. A store already written in ISSUE0 stays in RAM (partial word), with no `rsp_valid`.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Half with A0[0]=1, or word with A0[1:0]≠0, performs no RAM write or read.
  - FSM goes IDLE -> DONE directly.
  - `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, 1 cycle after accept.
- Undefined: misaligned accesses are sequenced byte-wise as above; `rsp_err` is tied 0.

Test Plan:
- Word store addr 0x100, data 0xDEADBEEF -> `we_a`/`we_b` high for 2 consecutive cycles at 0x100/0x101 then 0x102/0x103; `rsp_valid` 3 cycles after accept; RAM holds EF BE AD DE.
- Word load addr 0x100 after the previous store -> `rsp_rdata`=0xDEADBEEF, `rsp_valid` 4 cycles after accept, `req_ready` low for 4 cycles.
- Byte load 0x103 signed -> 0xFFFFFFDE; LBU -> 0x000000DE; half load 0x102 signed -> 0xFFFFDEAD.
- Word store addr 0x7FFE, data 0x11223344 -> bytes written at 0x7FFE, 0x7FFF, 0x0000, 0x0001; load back returns 0x11223344 (macro undefined).
- Assert `rst` during ISSUE1 of a word store -> ISSUE1 writes suppressed, `req_ready`=1, no `rsp_valid`; bytes 0x100/0x101 updated, 0x102/0x103 unchanged.
- With DMEM_MISALIGN_TRAP_EN defined, word load 0x101 -> no RAM activity, `rsp_valid`=1 and `rsp_err`=1 one cycle after accept, `rsp_rdata`=0.

Source files
------------

// File: rtl/dmem_byte_sequencer.sv
// Load/store sequencer onto a byte-wide dual-port RAM, two byte lanes per cycle.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.

module dmem_byte_lane #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              we_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wdata_o,
  output logic              we_o
);
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;

  // Address/data hold between loads; the strobe lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (ld_i) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      we_q    <= we_i;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;
endmodule

module dmem_byte_sequencer #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] ram_addr_a_o,
  output logic [7:0]        ram_wdata_a_o,
  output logic              ram_we_a_o,
  input  logic [7:0]        ram_rdata_a_i,
  output logic [ADDR_W-1:0] ram_addr_b_o,
  output logic [7:0]        ram_wdata_b_o,
  output logic              ram_we_b_o,
  input  logic [7:0]        ram_rdata_b_i
);
  localparam int NUM_LANES = 2;

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPT, DONE} state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] base;
    logic [15:0]       wdata_hi;
  } req_t;

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] ext;
  logic        accept, trap, is_word;
  logic        lane_ld;
  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr_d, lane_addr_q;
  logic [NUM_LANES-1:0][7:0]        lane_wdata_d, lane_wdata_q, lane_rdata;
  logic [NUM_LANES-1:0]             lane_we_d, lane_we_q;
  logic                             unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:ADDR_W];
  assign req_ready_o    = (state_q == IDLE);
  assign accept         = req_valid_i & req_ready_o;
  assign is_word        = req_q.size[1];
  assign lane_rdata     = {ram_rdata_b_i, ram_rdata_a_i};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign trap = (req_size_i == 2'b01 && req_addr_i[0]) ||
                (req_size_i[1] && req_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end

  assign rsp_err_o = (state_q == DONE) & err_q;
`else
  assign trap      = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rd_d         = rd_q;
    lane_ld      = 1'b0;
    lane_addr_d  = '0;
    lane_wdata_d = '0;
    lane_we_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.we       = req_we_i;
          req_d.size     = req_size_i;
          req_d.uns      = req_unsigned_i;
          req_d.base     = req_addr_i[ADDR_W-1:0];
          req_d.wdata_hi = req_wdata_i[31:16];
          // Cleared so trapped and store responses read back as zero.
          rd_d           = '0;
          if (trap) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE0;
            lane_ld = 1'b1;
            for (int l = 0; l < NUM_LANES; l++) begin
              lane_addr_d[l]  = req_addr_i[ADDR_W-1:0] + ADDR_W'(l);
              lane_wdata_d[l] = req_wdata_i[8*l +: 8];
            end
            lane_we_d[0] = req_we_i;
            lane_we_d[1] = req_we_i & (req_size_i != 2'b00);
          end
        end
      end
      ISSUE0: begin
        if (is_word) begin
          state_d = ISSUE1;
          lane_ld = 1'b1;
          for (int l = 0; l < NUM_LANES; l++) begin
            lane_addr_d[l]  = req_q.base + ADDR_W'(2 + l);
            lane_wdata_d[l] = req_q.wdata_hi[8*l +: 8];
            lane_we_d[l]    = req_q.we;
          end
        end else begin
          state_d = req_q.we ? DONE : CAPT;
        end
      end
      ISSUE1: begin
        // First pair's read data lands while the second pair is issued.
        if (!req_q.we) rd_d[15:0] = lane_rdata;
        state_d = req_q.we ? DONE : CAPT;
      end
      CAPT: begin
        if (is_word) rd_d[31:16] = lane_rdata;
        else         rd_d[15:0]  = lane_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld_i    (lane_ld),
      .addr_i  (lane_addr_d[l]),
      .wdata_i (lane_wdata_d[l]),
      .we_i    (lane_we_d[l]),
      .addr_o  (lane_addr_q[l]),
      .wdata_o (lane_wdata_q[l]),
      .we_o    (lane_we_q[l])
    );
  end

  assign ram_addr_a_o  = lane_addr_q[0];
  assign ram_wdata_a_o = lane_wdata_q[0];
  assign ram_we_a_o    = lane_we_q[0];
  assign ram_addr_b_o  = lane_addr_q[1];
  assign ram_wdata_b_o = lane_wdata_q[1];
  assign ram_we_b_o    = lane_we_q[1];

  always_comb begin
    ext = rd_q;
    case (req_q.size)
      2'b00:   ext = {{24{rd_q[7]  & ~req_q.uns}}, rd_q[7:0]};
      2'b01:   ext = {{16{rd_q[15] & ~req_q.uns}}, rd_q[15:0]};
      default: ext = rd_q;
    endcase
  end

  assign rsp_valid_o = (state_q == DONE);
  assign rsp_rdata_o = (state_q == DONE && !req_q.we) ? ext : 32'h0;
endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Scoreboard bench for dmem_byte_sequencer with a behavioural byte-wide dual-port RAM.
module tb_dmem_byte_sequencer;
  localparam int AW = 15;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [7:0]    ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic          ram_we_a, ram_we_b;

  always #5 clk = ~clk;

  dmem_byte_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ram_addr_a_o(ram_addr_a), .ram_wdata_a_o(ram_wdata_a), .ram_we_a_o(ram_we_a),
    .ram_rdata_a_i(ram_rdata_a),
    .ram_addr_b_o(ram_addr_b), .ram_wdata_b_o(ram_wdata_b), .ram_we_b_o(ram_we_b),
    .ram_rdata_b_i(ram_rdata_b)
  );

  // RAM model: registered read of old contents, zero-filled at the first edge.
  logic [7:0] mem [0:(1<<AW)-1];
  bit mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
      mem_ok = 1'b1;
    end
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] = ram_wdata_a;
    if (ram_we_b) mem[ram_addr_b] = ram_wdata_b;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts RAM strobes per transaction and checks each response.
  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (ram_we_a || ram_we_b) begin
        chk("port_addr_differ", {31'd0, ram_addr_a != ram_addr_b}, 32'd1);
        wr_cnt = wr_cnt + (ram_we_a ? 1 : 0) + (ram_we_b ? 1 : 0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp actual rdata=%h err=%b required=no response", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("latency", cyc - e.acc, e.lat);
          chk("ram_writes", wr_cnt, e.wr);
          chk("ready_low_in_done", {31'd0, req_ready}, 32'd0);
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int wr, input bit track);
    int n = 0;
    int acc_c;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=not ready required=ready within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_c = cyc;
    if (track) sb.push_back('{exp_rd, exp_err, lat, wr, acc_c});
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_we", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    chk("rst_addr", {2'd0, ram_addr_a, ram_addr_b}, 32'd0);
    chk("rst_wdata", {16'd0, ram_wdata_a, ram_wdata_b}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Word store / load, then sub-word loads over the same bytes.
    issue(1, 2'b10, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 3, 4, 1);
    drain();
    chk("mem_100", {24'd0, mem[15'h100]}, 32'hEF);
    chk("mem_101", {24'd0, mem[15'h101]}, 32'hBE);
    chk("mem_102", {24'd0, mem[15'h102]}, 32'hAD);
    chk("mem_103", {24'd0, mem[15'h103]}, 32'hDE);
    issue(0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 4, 0, 1);
    issue(0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'hFFFF_FFDE, 0, 3, 0, 1);
    issue(0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h0000_00DE, 0, 3, 0, 1);
    issue(0, 2'b01, 0, 32'h0000_0102, 32'h0, 32'hFFFF_DEAD, 0, 3, 0, 1);
    issue(0, 2'b01, 1, 32'h0000_0100, 32'h0, 32'h0000_BEEF, 0, 3, 0, 1);
    // Byte and half stores touch only their own lanes.
    issue(1, 2'b00, 0, 32'h0000_0104, 32'hAAAA_AA7F, 32'h0, 0, 2, 1, 1);
    issue(0, 2'b00, 0, 32'h0000_0104, 32'h0, 32'h0000_007F, 0, 3, 0, 1);
    issue(1, 2'b01, 0, 32'h0000_0106, 32'h1234_8001, 32'h0, 0, 2, 2, 1);
    issue(0, 2'b01, 0, 32'h0000_0106, 32'h0, 32'hFFFF_8001, 0, 3, 0, 1);
    drain();
    chk("mem_105_untouched", {24'd0, mem[15'h105]}, 32'h00);
    chk("mem_107", {24'd0, mem[15'h107]}, 32'h80);
    // Address wrap (misaligned word, so it traps when the feature is on).
    issue(1, 2'b10, 0, 32'hFFFF_7FFE, 32'h1122_3344, 32'h0, TRAP, TRAP ? 1 : 3, TRAP ? 0 : 4, 1);
    drain();
    chk("mem_7ffe", {24'd0, mem[15'h7FFE]}, TRAP ? 32'h00 : 32'h44);
    chk("mem_7fff", {24'd0, mem[15'h7FFF]}, TRAP ? 32'h00 : 32'h33);
    chk("mem_0000", {24'd0, mem[15'h0000]}, TRAP ? 32'h00 : 32'h22);
    chk("mem_0001", {24'd0, mem[15'h0001]}, TRAP ? 32'h00 : 32'h11);
    issue(0, 2'b10, 0, 32'h0000_7FFE, 32'h0, TRAP ? 32'h0 : 32'h1122_3344, TRAP, TRAP ? 1 : 4, 0, 1);
    // Size 11 behaves as word; misaligned half and word loads.
    issue(0, 2'b11, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 4, 0, 1);
    issue(0, 2'b01, 0, 32'h0000_0101, 32'h0, TRAP ? 32'h0 : 32'hFFFF_ADBE, TRAP, TRAP ? 1 : 3, 0, 1);
    issue(0, 2'b10, 0, 32'h0000_0101, 32'h0, TRAP ? 32'h0 : 32'h7FDE_ADBE, TRAP, TRAP ? 1 : 4, 0, 1);
    drain();

    // Reset during ISSUE1 of a word store: first pair lands, second does not.
    issue(1, 2'b10, 0, 32'h0000_0100, 32'h4433_2211, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_we", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_mem_100", {24'd0, mem[15'h100]}, 32'h11);
    chk("midrst_mem_101", {24'd0, mem[15'h101]}, 32'h22);
    chk("midrst_mem_102", {24'd0, mem[15'h102]}, 32'hAD);
    chk("midrst_mem_103", {24'd0, mem[15'h103]}, 32'hDE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
